// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable frame width, multiple active-low selects,
// LSB/MSB-first ordering, selectable SPI mode, select hold across frames, and abort.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 4,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic              i_hold_ss,
  input  logic              i_abort,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic [SEL_W-1:0]  i_ss_sel,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_SS-1:0] o_ss_n
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWITCH,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_HELD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;
  logic              r_hold;
  logic [DIV_W-1:0]  r_div;
  logic [SEL_W-1:0]  r_sel;
  logic [DIV_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_busy;
  logic              r_sclk;
  logic              r_mosi;
  logic [NUM_SS-1:0] r_ss_n;

  logic w_abort;
  logic w_accept;
  logic w_half_done;
  logic w_last_edge;
  logic w_odd_edge;
  logic w_sample;
  logic w_shift;
  logic w_same_sel;

  // Out-of-range indices deselect every slave but still let the frame run.
  function automatic logic [NUM_SS-1:0] f_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (sel == SEL_W'(i)) v[i] = 1'b0;
    return v;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_abort     = i_abort && (r_state != S_IDLE);
    w_accept    = i_start && !w_abort && (r_state == S_IDLE || r_state == S_HELD);
    w_half_done = (r_cnt == r_div);
    w_last_edge = (r_edge == LAST_EDGE);
    w_odd_edge  = ~r_edge[0];
    w_sample    = r_cpha ? ~w_odd_edge : w_odd_edge;
    w_shift     = r_cpha ? (w_odd_edge && (r_edge != '0)) : (~w_odd_edge && !w_last_edge);
    w_same_sel  = (i_ss_sel == r_sel);
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) w_state_nxt = S_SETUP;
        S_HELD:   if (i_start) w_state_nxt = w_same_sel ? S_XFER : S_SWITCH;
        S_SWITCH: w_state_nxt = S_SETUP;
        S_SETUP:  if (w_half_done) w_state_nxt = S_XFER;
        S_XFER:   if (w_half_done && w_last_edge) w_state_nxt = S_HOLD;
        S_HOLD:   if (w_half_done) w_state_nxt = r_hold ? S_HELD : S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_hold     <= 1'b0;
      r_div      <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_ss_n <= '1;
        r_sclk <= r_cpol;
        r_busy <= 1'b0;
        r_cnt  <= '0;
        r_edge <= '0;
      end else if (w_accept) begin
        r_cpol  <= i_cpol;
        r_cpha  <= i_cpha;
        r_lsb   <= i_lsb_first;
        r_hold  <= i_hold_ss;
        r_div   <= i_clk_div;
        r_sel   <= i_ss_sel;
        r_tx_sh <= i_tx_data;
        r_rx_sh <= '0;
        r_mosi  <= i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_W-1];
        r_sclk  <= i_cpol;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_edge  <= '0;
        // Switching slaves from a held select inserts one fully deselected cycle.
        r_ss_n  <= (r_state == S_HELD && !w_same_sel) ? '1 : f_decode(i_ss_sel);
      end else begin
        case (r_state)
          S_IDLE:   r_sclk <= i_cpol;
          S_SWITCH: r_ss_n <= f_decode(r_sel);
          S_SETUP:  r_cnt  <= w_half_done ? '0 : r_cnt + 1'b1;
          S_HOLD: begin
            r_cnt <= w_half_done ? '0 : r_cnt + 1'b1;
            if (w_half_done) begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
              r_busy     <= 1'b0;
              if (!r_hold) r_ss_n <= '1;
            end
          end
          S_XFER: begin
            if (w_half_done) begin
              r_cnt  <= '0;
              r_sclk <= ~r_sclk;
              r_edge <= w_last_edge ? '0 : r_edge + 1'b1;
              if (w_sample)
                r_rx_sh <= r_lsb ? {i_miso, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], i_miso};
              if (w_shift) begin
                r_tx_sh <= r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
                r_mosi  <= r_lsb ? r_tx_sh[1] : r_tx_sh[DATA_W-2];
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_ss_n     = r_ss_n;

endmodule
